// File: rtl/mem_pkg.sv
// Shared constants for the DE10 load/store front end: RV32I size codes, FSM encoding,
// default bus-wait limit and the access legality check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  // Unsigned codes exist only for loads; halfwords need bit 0 clear, words both bits clear.
  function automatic logic access_ok(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] offset);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~offset[0];
      F3_W:    ok = (offset == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~offset[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: write strobes, store data shift and load extract/extend.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  assign shamt      = {offset, 3'b000};
  assign wdata_lane = wdata << shamt;
  assign shifted    = bus_rdata >> shamt;

  always_comb begin
    case (funct3[1:0])
      2'b00:   wstrb = 4'b0001 << offset;
      2'b01:   wstrb = 4'b0011 << offset;
      2'b10:   wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = shifted;
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/de10_mem_access_unit.sv
// Load/store front end between the core memory stage and the DE10 bus decoder.
// Optional bus-wait timeout compiled in with MEM_TIMEOUT_EN.
module de10_mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  logic [1:0]  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        latch;
  logic [3:0]  strb;
  logic [31:0] wdata_lane, load_data;

`ifdef MEM_TIMEOUT_EN
  logic [31:0] wait_q, wait_d;
`endif

  mem_lane_align u_lane_align (
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .bus_rdata  (bus_rdata),
    .wstrb      (strb),
    .wdata_lane (wdata_lane),
    .load_data  (load_data)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    latch   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          latch = 1'b1;
`ifdef MEM_TIMEOUT_EN
          wait_d = 32'h0;
`endif
          if (access_ok(we, funct3, addr[1:0])) begin
            state_d = ST_ACCESS;
            err_d   = 1'b0;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end
        end
      end
      ST_ACCESS: begin
        if (bus_ready) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : load_data;
        end
`ifdef MEM_TIMEOUT_EN
        // Ready in the limit cycle takes priority over the timeout.
        else if (wait_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          wait_d = wait_q + 32'd1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (latch) begin
        we_q     <= we;
        funct3_q <= funct3;
        addr_q   <= addr;
        wdata_q  <= wdata;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 32'h0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_req   = (state_q == ST_ACCESS);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wstrb = bus_we ? strb : 4'b0000;
  assign bus_wdata = wdata_lane;

endmodule

// File: tb/tb_de10_mem_access_unit.sv
// Directed self-checking bench for de10_mem_access_unit; timeout cases need MEM_TIMEOUT_EN.
module tb_de10_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TbTimeout = 4;
`else
  localparam int unsigned TbTimeout = 255;
`endif

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;

  int errors = 0;
  int checks = 0;

  // Observations from the most recent run_access call
  logic        r_done, r_err, r_stable, r_we;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_strb;
  int          r_lat, r_nacc;

  de10_mem_access_unit #(.TIMEOUT_CYCLES(TbTimeout)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  // Call at a negedge: raises req this cycle (cycle 0), ready after `delay` low ACCESS cycles.
  task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] bd, input int delay);
    r_done = 0; r_err = 0; r_rdata = 'x; r_lat = 0; r_nacc = 0; r_stable = 1;
    r_strb = 0; r_wdata = 0; r_addr = 0; r_we = 0;
    req = 1; we = w; funct3 = f3; addr = a; wdata = wd; bus_rdata = bd; bus_ready = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus_req) begin
        r_nacc++;
        if (r_nacc == 1) begin
          r_addr = bus_addr; r_strb = bus_wstrb; r_wdata = bus_wdata; r_we = bus_we;
        end else if (bus_addr !== r_addr || bus_wstrb !== r_strb || bus_wdata !== r_wdata ||
                     bus_we !== r_we) begin
          r_stable = 0;
        end
        bus_ready = (r_nacc > delay);
      end
      if (done) begin
        r_done = 1; r_err = err; r_rdata = rdata; r_lat = i;
        req = 0; bus_ready = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; req = 0; we = 0; funct3 = 0; addr = 0; wdata = 0; bus_rdata = 0; bus_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, bus_req, bus_we, bus_wstrb} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {busy, done, err, bus_req, bus_we, bus_wstrb});
    end
    checks++;
    if ({rdata, bus_addr, bus_wdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h bus_addr=%h bus_wdata=%h expected 0", rdata, bus_addr,
               bus_wdata);
    end
    rst = 0;
  endtask

  task automatic test_lw();
    @(negedge clk);
    run_access(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0);
    checks++;
    if (!r_done || r_lat != 2 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL lw_timing: done=%0b lat=%0d err=%b expected 1 2 0", r_done, r_lat, r_err);
    end
    checks++;
    if (r_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL lw_rdata: got %h expected deadbeef", r_rdata);
    end
    checks++;
    if (r_addr !== 32'h10 || r_we !== 1'b0 || r_strb !== 4'h0 || r_nacc != 1) begin
      errors++;
      $display("FAIL lw_bus: addr=%h we=%b strb=%b nacc=%0d expected 10 0 0000 1", r_addr, r_we,
               r_strb, r_nacc);
    end
  endtask

  task automatic test_sub_word_loads();
    @(negedge clk);
    run_access(1'b0, 3'b000, 32'h0040_0003, 32'h0, 32'h8012_3456, 0);
    checks++;
    if (r_rdata !== 32'hFFFF_FF80 || r_err !== 1'b0 || r_addr !== 32'h0040_0000) begin
      errors++;
      $display("FAIL lb: rdata=%h err=%b addr=%h expected ffffff80 0 00400000", r_rdata, r_err,
               r_addr);
    end
    @(negedge clk);
    run_access(1'b0, 3'b100, 32'h0040_0003, 32'h0, 32'h8012_3456, 0);
    checks++;
    if (r_rdata !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu: got %h expected 00000080", r_rdata);
    end
    @(negedge clk);
    run_access(1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_1234, 0);
    checks++;
    if (r_rdata !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL lh: got %h expected ffff8001", r_rdata);
    end
    @(negedge clk);
    run_access(1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h8001_1234, 0);
    checks++;
    if (r_rdata !== 32'h0000_8001) begin
      errors++;
      $display("FAIL lhu: got %h expected 00008001", r_rdata);
    end
  endtask

  task automatic test_stores();
    @(negedge clk);
    run_access(1'b1, 3'b001, 32'h0080_0002, 32'h0000_ABCD, 32'h1234_5678, 5);
    checks++;
    if (r_strb !== 4'b1100 || r_wdata !== 32'hABCD_0000 || r_we !== 1'b1) begin
      errors++;
      $display("FAIL sh_lanes: strb=%b wdata=%h we=%b expected 1100 abcd0000 1", r_strb, r_wdata,
               r_we);
    end
    checks++;
    if (r_nacc != 6 || !r_stable || r_addr !== 32'h0080_0000 || r_lat != 7) begin
      errors++;
      $display("FAIL sh_hold: nacc=%0d stable=%b addr=%h lat=%0d expected 6 1 00800000 7", r_nacc,
               r_stable, r_addr, r_lat);
    end
    checks++;
    if (r_rdata !== 32'h0 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL sh_result: rdata=%h err=%b expected 0 0", r_rdata, r_err);
    end
    @(negedge clk);
    run_access(1'b1, 3'b000, 32'h0000_0101, 32'hAABB_CC56, 32'h0, 0);
    checks++;
    if (r_strb !== 4'b0010 || r_wdata !== 32'hBBCC_5600 || r_lat != 2) begin
      errors++;
      $display("FAIL sb_lanes: strb=%b wdata=%h lat=%0d expected 0010 bbcc5600 2", r_strb,
               r_wdata, r_lat);
    end
  endtask

  task automatic test_errors();
    logic [2:0]  f3s   [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
    logic [31:0] addrs [4] = '{32'h2, 32'h0, 32'h5, 32'h8};
    logic        wes   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      // A good load first leaves a nonzero rdata the error must clear.
      @(negedge clk);
      run_access(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h5555_AAAA, 0);
      @(negedge clk);
      run_access(wes[k], f3s[k], addrs[k], 32'h0, 32'h5555_AAAA, 0);
      checks++;
      if (!r_done || r_lat != 1 || r_err !== 1'b1 || r_rdata !== 32'h0 || r_nacc != 0) begin
        errors++;
        $display("FAIL err_case%0d: done=%0b lat=%0d err=%b rdata=%h nacc=%0d expected 1 1 1 0 0",
                 k, r_done, r_lat, r_err, r_rdata, r_nacc);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_access(1'b1, 3'b010, 32'h0000_0040, 32'h1122_3344, 32'h0, 0);
    checks++;
    if (r_strb !== 4'b1111 || r_wdata !== 32'h1122_3344 || r_lat != 2) begin
      errors++;
      $display("FAIL b2b_sw: strb=%b wdata=%h lat=%0d expected 1111 11223344 2", r_strb, r_wdata,
               r_lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: done=%b busy=%b err=%b expected 0 0 0", done, busy, err);
    end
    run_access(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 0);
    checks++;
    if (r_lat != 2 || r_rdata !== 32'hCAFE_F00D || r_addr !== 32'h44) begin
      errors++;
      $display("FAIL b2b_lw: lat=%0d rdata=%h addr=%h expected 2 cafef00d 44", r_lat, r_rdata,
               r_addr);
    end
  endtask

  task automatic test_reset_mid_access();
    int n = 0;
    logic saw_done = 0;
    @(negedge clk);
    req = 1; we = 0; funct3 = 3'b010; addr = 32'h30; bus_rdata = 32'h0; bus_ready = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_req) n++;
      if (n == 3) break;
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (n != 3 || bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: n=%0d bus_req=%b busy=%b done=%b expected 3 0 0 0", n, bus_req, busy,
               done);
    end
    rst = 0; req = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || bus_req) saw_done = 1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_abandon: activity seen=%b expected 0", saw_done);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    run_access(1'b0, 3'b010, 32'h0000_0050, 32'h0, 32'h0102_0304, 100);
    checks++;
    if (!r_done || r_err !== 1'b1 || r_nacc != 4 || r_lat != 5 || r_rdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout: done=%0b err=%b nacc=%0d lat=%0d rdata=%h expected 1 1 4 5 0",
               r_done, r_err, r_nacc, r_lat, r_rdata);
    end
    @(negedge clk);
    run_access(1'b0, 3'b010, 32'h0000_0050, 32'h0, 32'h0102_0304, 3);
    checks++;
    if (!r_done || r_err !== 1'b0 || r_lat != 5 || r_rdata !== 32'h0102_0304) begin
      errors++;
      $display("FAIL timeout_ready_wins: done=%0b err=%b lat=%0d rdata=%h expected 1 0 5 01020304",
               r_done, r_err, r_lat, r_rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
